// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// It retires one bit per cycle, and every operation takes WIDTH+2 edges.
// Optional build macro: MULDIV_SIGNED_EN. When it is defined, op[0] selects
// signed handling, which adds the magnitude step and the result negators.
// When it is undefined, op[0] is ignored and no sign logic is built.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    // Operation request as captured when start is accepted
    typedef struct packed {
        logic             is_div;
        logic [WIDTH-1:0] rs;
        logic [WIDTH-1:0] rt;
    } req_t;

    state_t             state;
    req_t               req;
    logic [2*WIDTH-1:0] acc;    // {remainder|product-hi, quotient|product-lo}
    logic [WIDTH-1:0]   opb;    // multiplicand / divisor magnitude
    logic [CW-1:0]      cnt;
    logic               dz_q;

`ifdef MULDIV_SIGNED_EN
    logic sgn_op, sign_q, sign_r;
`else
    logic op_unused;
    assign op_unused = op[0];
`endif

    // Datapath wires
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    // One shift-add and one restoring shift-subtract step on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift[WIDTH-1:0] - opb;
        div_next  = {(div_ok ? div_diff : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ok};
    end

    // Operand magnitudes going in and sign correction coming out
    always_comb begin
        rs_mag   = req.rs;
        rt_mag   = req.rt;
        prod_fix = acc;
        quot_fix = acc[WIDTH-1:0];
        rem_fix  = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (sgn_op && req.rs[WIDTH-1]) rs_mag = -req.rs;
        if (sgn_op && req.rt[WIDTH-1]) rt_mag = -req.rt;
        if (sign_q) begin
            prod_fix = -acc;
            quot_fix = -acc[WIDTH-1:0];
        end
        if (sign_r) rem_fix = -acc[2*WIDTH-1:WIDTH];
`endif
    end

    // Sequencer FSM with registered HI/LO and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            req      <= '0;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            dz_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_op   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        req.is_div <= op[1];
                        req.rs     <= rs_val;
                        req.rt     <= rt_val;
`ifdef MULDIV_SIGNED_EN
                        sgn_op     <= op[0];
`endif
                        busy       <= 1'b1;
                        state      <= S_PREP;
                    end else if (hilo_we) begin
                        // start wins over a same-cycle direct write
                        if (hilo_sel) hi <= hilo_wdata;
                        else          lo <= hilo_wdata;
                    end
                end
                S_PREP: begin
                    acc   <= {{WIDTH{1'b0}}, rs_mag};
                    opb   <= rt_mag;
                    cnt   <= CW'(WIDTH - 1);
                    dz_q  <= req.is_div && (req.rt == '0);
`ifdef MULDIV_SIGNED_EN
                    sign_q <= sgn_op & (req.rs[WIDTH-1] ^ req.rt[WIDTH-1]);
                    sign_r <= sgn_op & req.rs[WIDTH-1];
`endif
                    state <= S_RUN;
                end
                S_RUN: begin
                    acc <= req.is_div ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    if (req.is_div) begin
                        // A zero divisor ran the full loop; its result is replaced here
                        if (dz_q) begin
                            hi <= req.rs;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                        div_zero <= dz_q;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq. The reference is plain 64-bit
// arithmetic, which follows MULDIV_SIGNED_EN in the same way as the design.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        hilo_we, hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference architectural state
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_we(hilo_we),
        .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata), .busy(busy),
        .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, using plain integer arithmetic
    task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit     sg;
        longint sa, sb, q, r;
        logic [63:0] p;
        sg = SGN && o[0];
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else begin
            if (b == 32'd0) begin
                m_hi = a;
                m_lo = 32'hFFFF_FFFF;
                m_dz = 1'b1;
            end else begin
                q = sa / sb;
                r = sa % sb;
                m_lo = 32'(q);
                m_hi = 32'(r);
                m_dz = 1'b0;
            end
        end
    endtask

    // Issue one op from a negedge; return at the negedge where done is seen.
    // mode 1: pulse start and hilo_we during RUN. mode 2: hilo_we alongside start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
        int cyc, bcnt;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        if (mode == 2) begin
            hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        cyc = 1; bcnt = 0;
        if (mode == 2) chk("we_with_start", hi, m_hi);
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
            if (mode == 1 && cyc == 10) begin
                start = 1'b1; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
                hilo_we = 1'b1; hilo_sel = 1'($urandom); hilo_wdata = $urandom;
            end
            if (mode == 1 && cyc == 12) begin
                start = 1'b0; hilo_we = 1'b0;
            end
        end
        ref_op(o, a, b);
        chk("latency", 64'(cyc - 1), 64'd34);
        chk("busy_cycles", 64'(bcnt), 64'd34);
        chk("busy_at_done", busy, 1'b0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_zero", div_zero, m_dz);
    endtask

    // One idle cycle after an op: done must have been a single pulse
    task automatic idle_check();
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", div_zero, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the plan
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);
        idle_check();
        do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 0);
        chk("mult_m3x5_hi", hi, SGN ? 32'hFFFF_FFFF : 32'h0000_0004);
        chk("mult_m3x5_lo", lo, 32'hFFFF_FFF1);
        idle_check();
        do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        idle_check();
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle_check();
        do_op(2'b10, 32'h0000_0064, 32'h0000_0000, 0);
        chk("divu_z_hi", hi, 32'h64);
        chk("divu_z_lo", lo, 32'hFFFF_FFFF);
        chk("divu_z_flag", div_zero, 1'b1);
        // Back-to-back: start asserted in the done cycle
        do_op(2'b10, 32'h0000_0064, 32'h0000_0007, 0);
        chk("divu_7_lo", lo, 32'h0E);
        chk("divu_7_hi", hi, 32'h02);
        chk("divu_7_flag", div_zero, 1'b0);
        idle_check();

        // Disturbance during RUN, then same-cycle write+start
        do_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1);
        idle_check();
        do_op(2'b00, 32'h0000_0003, 32'h0000_0009, 2);
        idle_check();

        // Direct writes
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234_5678;
        @(negedge clk);
        hilo_we = 1'b0;
        m_hi = 32'h1234_5678;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_lo", lo, m_lo);
        chk("mthi_no_done", done, 1'b0);
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hilo_we = 1'b0;
        m_lo = 32'hCAFE_F00D;
        chk("mtlo_lo", lo, m_lo);
        chk("mtlo_hi", hi, m_hi);
        chk("mtlo_no_done", done, 1'b0);

        // Randomised ops, mixing back-to-back and idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            int r;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) a = a >> $urandom_range(0, 31);
            do_op(o, a, b, 0);
            if (r[0]) idle_check();
        end
        idle_check();

        // Asynchronous reset in the middle of RUN
        start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_0001; rt_val = 32'h0001_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_dz", div_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(2'b00, 32'd6, 32'd7, 0);
        chk("post_rst_lo", lo, 32'h2A);
        chk("post_rst_hi", hi, 32'h0);
        idle_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
